// File: rtl/inert_spi_seq.sv
// Inertial-sensor command sequencer: power-up wait, 4 config writes, then INT-triggered burst reads.
// Optional build macro INT_SYNC_EN inserts a 2-flop synchronizer on INT ahead of the edge detector.
module inert_spi_seq #(
  parameter int          INIT_CNT_W = 16,
  parameter logic [15:0] CFG0       = 16'h0D02,
  parameter logic [15:0] CFG1       = 16'h1053,
  parameter logic [15:0] CFG2       = 16'h1150,
  parameter logic [15:0] CFG3       = 16'h1460
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        INT,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic        wrt,
  output logic [15:0] cmd,
  output logic        init_done,
  output logic [15:0] ptch_rt,
  output logic [15:0] yaw_rt,
  output logic        vld
);

  typedef enum logic [2:0] {
    PWR_WAIT = 3'd0,
    CFG_SEND = 3'd1,
    CFG_WAIT = 3'd2,
    IDLE     = 3'd3,
    RD_SEND  = 3'd4,
    RD_WAIT  = 3'd5,
    DONE_UPD = 3'd6
  } state_t;

  state_t                 state_r, state_s;
  logic [INIT_CNT_W-1:0]  cnt_r;
  logic [1:0]             idx_r, idx_s;
  logic                   pending_r, pending_s;
  logic [3:0][7:0]        byte_r, byte_s;
  logic                   done_q_r, done_rise_s;
  logic                   int_d_r, int_q_r, int_rise_s, int_src_s;
  logic                   wrt_s, vld_s, init_done_s;
  logic [15:0]            cmd_s, ptch_s, yaw_s;
  logic                   unused_hi_s;

  assign unused_hi_s = ^rd_data[15:8];

  function automatic logic [15:0] cfg_word(input logic [1:0] i);
    case (i)
      2'd0:    cfg_word = CFG0;
      2'd1:    cfg_word = CFG1;
      2'd2:    cfg_word = CFG2;
      2'd3:    cfg_word = CFG3;
      default: cfg_word = CFG0;
    endcase
  endfunction

  function automatic logic [15:0] rd_word(input logic [1:0] i);
    case (i)
      2'd0:    rd_word = 16'hA200;
      2'd1:    rd_word = 16'hA300;
      2'd2:    rd_word = 16'hA600;
      2'd3:    rd_word = 16'hA700;
      default: rd_word = 16'hA200;
    endcase
  endfunction

`ifdef INT_SYNC_EN
  logic sync0_r, sync1_r;

  // Two-flop synchronizer for the asynchronous INT line
  always_ff @(posedge clk) begin
    if (rst) begin
      sync0_r <= 1'b0;
      sync1_r <= 1'b0;
    end else begin
      sync0_r <= INT;
      sync1_r <= sync0_r;
    end
  end
  assign int_src_s = sync1_r;
`else
  assign int_src_s = INT;
`endif

  // Edge detectors for INT and done
  always_ff @(posedge clk) begin
    if (rst) begin
      int_d_r  <= 1'b0;
      int_q_r  <= 1'b0;
      done_q_r <= 1'b0;
    end else begin
      int_d_r  <= int_src_s;
      int_q_r  <= int_d_r;
      done_q_r <= done;
    end
  end

  assign int_rise_s  = int_d_r & ~int_q_r;
  assign done_rise_s = done & ~done_q_r;

  // State register and sequencing datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= PWR_WAIT;
      cnt_r     <= '0;
      idx_r     <= 2'd0;
      pending_r <= 1'b0;
      byte_r    <= '0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= (state_r == PWR_WAIT) ? cnt_r + INIT_CNT_W'(1) : cnt_r;
      idx_r     <= idx_s;
      pending_r <= pending_s;
      byte_r    <= byte_s;
    end
  end

  // Next-state, index, pending-flag and byte-capture logic
  always_comb begin
    state_s   = state_r;
    idx_s     = idx_r;
    pending_s = pending_r;
    byte_s    = byte_r;
    case (state_r)
      PWR_WAIT: begin
        if (&cnt_r) begin
          state_s = CFG_SEND;
          idx_s   = 2'd0;
        end else begin
          state_s = PWR_WAIT;
        end
      end
      CFG_SEND: state_s = CFG_WAIT;
      CFG_WAIT: begin
        if (done_rise_s) begin
          if (idx_r == 2'd3) begin
            state_s = IDLE;
          end else begin
            idx_s   = idx_r + 2'd1;
            state_s = CFG_SEND;
          end
        end else begin
          state_s = CFG_WAIT;
        end
      end
      IDLE: begin
        if (int_rise_s || pending_r) begin
          state_s   = RD_SEND;
          idx_s     = 2'd0;
          pending_s = 1'b0;
        end else begin
          state_s = IDLE;
        end
      end
      RD_SEND: begin
        state_s   = RD_WAIT;
        pending_s = pending_r | int_rise_s;
      end
      RD_WAIT: begin
        pending_s = pending_r | int_rise_s;
        if (done_rise_s) begin
          byte_s[idx_r] = rd_data[7:0];
          if (idx_r == 2'd3) begin
            state_s = DONE_UPD;
          end else begin
            idx_s   = idx_r + 2'd1;
            state_s = RD_SEND;
          end
        end else begin
          state_s = RD_WAIT;
        end
      end
      DONE_UPD: begin
        state_s   = IDLE;
        pending_s = pending_r | int_rise_s;
      end
      default: state_s = PWR_WAIT;
    endcase
  end

  // Output next-values, decoded from the upcoming state so outputs line up with it
  always_comb begin
    wrt_s       = (state_s == CFG_SEND) || (state_s == RD_SEND);
    vld_s       = (state_s == DONE_UPD);
    init_done_s = init_done | ((state_r == CFG_WAIT) && (state_s == IDLE));
    if (state_s == CFG_SEND) begin
      cmd_s = cfg_word(idx_s);
    end else if (state_s == RD_SEND) begin
      cmd_s = rd_word(idx_s);
    end else begin
      cmd_s = cmd;
    end
    // Both rates load together so a reader never sees a mixed pair
    if (state_s == DONE_UPD) begin
      ptch_s = {byte_s[1], byte_s[0]};
      yaw_s  = {byte_s[3], byte_s[2]};
    end else begin
      ptch_s = ptch_rt;
      yaw_s  = yaw_rt;
    end
  end

  // Registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      wrt       <= 1'b0;
      cmd       <= 16'h0000;
      init_done <= 1'b0;
      ptch_rt   <= 16'h0000;
      yaw_rt    <= 16'h0000;
      vld       <= 1'b0;
    end else begin
      wrt       <= wrt_s;
      cmd       <= cmd_s;
      init_done <= init_done_s;
      ptch_rt   <= ptch_s;
      yaw_rt    <= yaw_s;
      vld       <= vld_s;
    end
  end

endmodule

// File: tb/tb_inert_spi_seq.sv
// Directed bench for inert_spi_seq with a bus-functional SPI master model (done 10 cycles after wrt).
module tb_inert_spi_seq;
  logic        clk = 1'b0;
  logic        rst;
  logic        int_pin;
  logic        done = 1'b0;
  logic [15:0] rd_data = 16'h0000;
  logic        wrt, init_done, vld;
  logic [15:0] cmd, ptch_rt, yaw_rt;

  int vectors = 0;
  int miscompares = 0;

  inert_spi_seq #(.INIT_CNT_W(4)) dut (
    .clk(clk), .rst(rst), .INT(int_pin), .done(done), .rd_data(rd_data),
    .wrt(wrt), .cmd(cmd), .init_done(init_done), .ptch_rt(ptch_rt),
    .yaw_rt(yaw_rt), .vld(vld)
  );

  always #5 clk = ~clk;

  // SPI master model
  logic [3:0]  bfm_cnt = 4'd0;
  logic [15:0] bfm_cmd = 16'h0000;
  logic [7:0]  rp_lo, rp_hi, ry_lo, ry_hi;

  function automatic logic [7:0] resp_byte(input logic [15:0] c);
    case (c)
      16'hA200: resp_byte = rp_lo;
      16'hA300: resp_byte = rp_hi;
      16'hA600: resp_byte = ry_lo;
      16'hA700: resp_byte = ry_hi;
      default:  resp_byte = 8'h00;
    endcase
  endfunction

  always @(posedge clk) begin
    if (wrt === 1'b1) begin
      done    <= 1'b0;
      bfm_cnt <= 4'd9;
      bfm_cmd <= cmd;
    end else if (bfm_cnt != 4'd0) begin
      bfm_cnt <= bfm_cnt - 4'd1;
      if (bfm_cnt == 4'd1) begin
        done    <= 1'b1;
        rd_data <= {8'hEE, resp_byte(bfm_cmd)};
      end
    end
  end

  // Transaction monitor
  logic [15:0] cmd_log [$];
  int          vld_count = 0;
  int          wrt_double = 0;
  logic        prev_wrt = 1'b0;

  always @(posedge clk) begin
    if (wrt === 1'b1) begin
      cmd_log.push_back(cmd);
      if (prev_wrt) wrt_double++;
    end
    prev_wrt <= (wrt === 1'b1);
    if (vld === 1'b1) vld_count++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  int n;
  int base;
  int exp_lat;

  initial begin
    rst = 1'b1; int_pin = 1'b0;
    rp_lo = 8'h34; rp_hi = 8'h12; ry_lo = 8'h78; ry_hi = 8'h56;
    repeat (3) tick();
    check("rst_wrt", {31'd0, wrt}, 32'd0);
    check("rst_cmd", {16'd0, cmd}, 32'd0);
    check("rst_init_done", {31'd0, init_done}, 32'd0);
    check("rst_ptch", {16'd0, ptch_rt}, 32'd0);
    check("rst_yaw", {16'd0, yaw_rt}, 32'd0);
    check("rst_vld", {31'd0, vld}, 32'd0);

    // Power-up wait, with an INT pulse that must be ignored
    rst = 1'b0;
    n = 0;
    do begin
      tick(); n++;
      if (n == 5) int_pin = 1'b1;
      if (n == 7) int_pin = 1'b0;
    end while (wrt !== 1'b1 && n < 40);
    check("pwr_wait_cycles", n, 32'd16);
    n = 0;
    while (init_done !== 1'b1 && n < 300) begin tick(); n++; end
    check("init_done_set", {31'd0, init_done}, 32'd1);
    check("cfg_count", cmd_log.size(), 32'd4);
    check("cfg0", {16'd0, cmd_log[0]}, 32'h0D02);
    check("cfg1", {16'd0, cmd_log[1]}, 32'h1053);
    check("cfg2", {16'd0, cmd_log[2]}, 32'h1150);
    check("cfg3", {16'd0, cmd_log[3]}, 32'h1460);
    repeat (30) tick();
    check("no_read_before_init", cmd_log.size(), 32'd4);
    check("no_vld_before_init", vld_count, 32'd0);
    check("ptch_untouched", {16'd0, ptch_rt}, 32'd0);

    // Single burst read and INT-to-wrt latency
    int_pin = 1'b1;
    n = 0;
    do begin tick(); n++; end while (wrt !== 1'b1 && n < 20);
    int_pin = 1'b0;
`ifdef INT_SYNC_EN
    exp_lat = 4;
`else
    exp_lat = 2;
`endif
    check("int_to_wrt_latency", n, exp_lat);
    n = 0;
    while (vld !== 1'b1 && n < 300) begin tick(); n++; end
    check("burst1_vld", {31'd0, vld}, 32'd1);
    check("burst1_ptch", {16'd0, ptch_rt}, 32'h1234);
    check("burst1_yaw", {16'd0, yaw_rt}, 32'h5678);
    tick();
    check("vld_one_cycle", {31'd0, vld}, 32'd0);
    check("ptch_held", {16'd0, ptch_rt}, 32'h1234);
    check("rd0", {16'd0, cmd_log[4]}, 32'hA200);
    check("rd1", {16'd0, cmd_log[5]}, 32'hA300);
    check("rd2", {16'd0, cmd_log[6]}, 32'hA600);
    check("rd3", {16'd0, cmd_log[7]}, 32'hA700);
    check("vld_count_1", vld_count, 32'd1);

    // Burst with three INT pulses during it: exactly one queued follow-up burst
    rp_lo = 8'hCD; rp_hi = 8'hAB; ry_lo = 8'h01; ry_hi = 8'hEF;
    int_pin = 1'b1;
    n = 0;
    do begin tick(); n++; end while (wrt !== 1'b1 && n < 20);
    int_pin = 1'b0;
    repeat (3) tick();
    for (int k = 0; k < 3; k++) begin
      int_pin = 1'b1; repeat (3) tick();
      int_pin = 1'b0; repeat (3) tick();
    end
    n = 0;
    while (vld !== 1'b1 && n < 300) begin tick(); n++; end
    check("burst2_vld", {31'd0, vld}, 32'd1);
    n = 0;
    do begin tick(); n++; end while (wrt !== 1'b1 && n < 20);
    check("pending_burst_gap", n, 32'd2);
    n = 0;
    while (vld !== 1'b1 && n < 300) begin tick(); n++; end
    check("burst3_ptch", {16'd0, ptch_rt}, 32'hABCD);
    check("burst3_yaw", {16'd0, yaw_rt}, 32'hEF01);
    // done stays high from the model for the whole idle stretch
    repeat (60) tick();
    check("vld_count_3", vld_count, 32'd3);
    check("log_size_16", cmd_log.size(), 32'd16);
    check("q_rd0", {16'd0, cmd_log[12]}, 32'hA200);
    check("q_rd3", {16'd0, cmd_log[15]}, 32'hA700);
    check("wrt_single_cycle", wrt_double, 32'd0);

    // Reset in RD_WAIT after two bytes, then full re-init
    base = cmd_log.size();
    int_pin = 1'b1;
    n = 0;
    while (cmd_log.size() < base + 3 && n < 300) begin tick(); n++; end
    int_pin = 1'b0;
    tick();
    check("third_read_issued", cmd_log.size(), base + 3);
    rst = 1'b1;
    tick();
    check("mid_rst_wrt", {31'd0, wrt}, 32'd0);
    check("mid_rst_ptch", {16'd0, ptch_rt}, 32'd0);
    check("mid_rst_yaw", {16'd0, yaw_rt}, 32'd0);
    check("mid_rst_vld", {31'd0, vld}, 32'd0);
    check("mid_rst_init_done", {31'd0, init_done}, 32'd0);
    check("mid_rst_cmd", {16'd0, cmd}, 32'd0);
    rst = 1'b0;
    n = 0;
    do begin tick(); n++; end while (wrt !== 1'b1 && n < 40);
    check("reinit_wait_cycles", n, 32'd16);
    n = 0;
    while (init_done !== 1'b1 && n < 300) begin tick(); n++; end
    check("reinit_done", {31'd0, init_done}, 32'd1);
    check("reinit_cfg0", {16'd0, cmd_log[base + 3]}, 32'h0D02);
    check("reinit_cfg1", {16'd0, cmd_log[base + 4]}, 32'h1053);
    check("reinit_cfg2", {16'd0, cmd_log[base + 5]}, 32'h1150);
    check("reinit_cfg3", {16'd0, cmd_log[base + 6]}, 32'h1460);
    repeat (20) tick();
    check("reinit_log_size", cmd_log.size(), base + 7);
    check("final_wrt_single_cycle", wrt_double, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/inert_spi_seq.md
Name: inert_spi_seq

Overview:
- Command sequencer directly upstream of the 16-bit SPI master. It drives the master's wrt/cmd inputs and consumes its done/rd_data outputs.
- After reset it waits for sensor power-up, then writes a fixed 4-entry configuration table to the inertial sensor.
- After that, each rising edge of the sensor's INT line triggers a 4-transaction burst read of pitch-rate and yaw-rate bytes.
- The assembled 16-bit rates are presented with a one-cycle valid pulse for the balance-control logic.

Parameters:
- INIT_CNT_W, 16, width of power-up wait counter; wait lasts 2^INIT_CNT_W clk cycles.
- CFG0, 16'h0D02, config write 0 (INT pin enable).
- CFG1, 16'h1053, config write 1 (accel ODR/range).
- CFG2, 16'h1150, config write 2 (gyro ODR/range).
- CFG3, 16'h1460, config write 3 (rounding).

Ports:
- clk  in  1  system clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- INT  in  1  sensor data-ready, asynchronous to clk
- done  in  1  SPI master done; level, cleared by master on wrt
- rd_data  in  16  SPI master read data; low byte valid when done rises
- wrt  out  1  one-cycle start pulse to SPI master
- cmd  out  16  SPI command word to master
- init_done  out  1  high once all 4 config writes complete
- ptch_rt  out  16  pitch rate {high byte, low byte}
- yaw_rt  out  16  yaw rate {high byte, low byte}
- vld  out  1  one-cycle pulse when ptch_rt/yaw_rt update

Behaviour:
- Reset values (rst sampled on clk edge):
  - wrt=0, cmd=16'h0000, init_done=0, ptch_rt=0, yaw_rt=0, vld=0.
  - State returns to PWR_WAIT; wait counter, index, pending flag and byte holding registers cleared.
  - Reset mid-transaction abandons the sequence with no further wrt; the SPI master's outstanding transfer is ignored.
- done_rise = done & ~done_q (done_q is a registered copy). All advancement is keyed on done_rise, never on the done level.
- States:
  - PWR_WAIT: counter increments each cycle; on all-ones → CFG_SEND with idx=0.
  - CFG_SEND: cmd=CFG[idx], wrt=1 for exactly this cycle → CFG_WAIT.
  - CFG_WAIT: on done_rise: if idx==3 → IDLE and set init_done=1 (stays 1 until rst); else idx++ → CFG_SEND.
  - IDLE: if int_rise or pending → RD_SEND with idx=0; clear pending.
  - RD_SEND: cmd from read table, wrt=1 for exactly this cycle → RD_WAIT.
    - idx0 = 16'hA200, pitch low.
    - idx1 = 16'hA300, pitch high.
    - idx2 = 16'hA600, yaw low.
    - idx3 = 16'hA700, yaw high.
  - RD_WAIT: on done_rise, capture rd_data[7:0] into holding byte[idx]. If idx==3 → DONE_UPD; else idx++ → RD_SEND.
  - DONE_UPD: ptch_rt<={byte1,byte0}, yaw_rt<={byte3,byte2}, both in the same cycle; vld=1 for this cycle → IDLE.
- cmd is registered and held stable from the wrt cycle until the next SEND state.
- Minimum gap between wrt pulses: one WAIT cycle plus the SPI transfer duration.
- int_rise = INT edge detected after the synchronizer. INT edges are ignored before init_done.
- int_rise during RD_SEND, RD_WAIT or DONE_UPD sets a single pending flag.
  - Additional edges while pending is already set are dropped; only one read is queued.
- Latency from int_rise in IDLE to wrt: 1 cycle (default build) after the synchronizer delay.
- rd_data[15:8] is ignored. Outputs change only as stated above; ptch_rt/yaw_rt never show a partially updated pair.

Optional Feature:
- INT_SYNC_EN:
  - Defined: INT passes through a 2-flop synchronizer, then the edge detector. int_rise occurs 3 clk cycles after INT rises.
  - Undefined: INT feeds the edge detector directly (INT assumed synchronous to clk). int_rise occurs 1 cycle after INT rises.
- Both builds use the identical state machine and pending-flag behaviour.

Test Plan:
1. Use INIT_CNT_W=4 with a bus-functional SPI model whose done rises 10 cycles after wrt. Release rst → after 16 cycles, 4 wrt pulses occur with cmd 0D02, 1053, 1150, 1460 in order, each wrt exactly 1 cycle. Then init_done=1.
2. After init, pulse INT; model returns 0x34, 0x12, 0x78, 0x56 → cmd sequence A200, A300, A600, A700. Then vld one cycle with ptch_rt=16'h1234 and yaw_rt=16'h5678.
3. Pulse INT before init_done=1 → no read wrt issued; ptch_rt and vld unchanged.
4. Pulse INT three times during an active read burst → exactly one further burst follows immediately, then IDLE; total vld pulses = 2.
5. Assert rst while in RD_WAIT after 2 bytes → next cycle wrt=0, ptch_rt=0, vld=0, init_done=0. Full re-init sequence repeats.
6. Hold done high for 50 cycles in the model → only one advance per done rise; no extra wrt. Run with and without INT_SYNC_EN and check INT-to-wrt latency of 4 vs 2 cycles.
